// File: rtl/riscv_pkg.sv
// Shared fetch-stage types: datapath width, fetch FSM states and the
// {pc, insn} record carried through the instruction buffer.
package riscv_pkg;

   localparam int XLEN       = 32;
   localparam int INSN_BYTES = 4;

   typedef enum logic [1:0] {
      S_BOOT,
      S_RUN,
      S_HALT
   } fetch_state_e;

   typedef struct packed {
      logic [31:0] pc;
      logic [31:0] insn;
   } fetch_entry_t;

   // Force a byte address onto a word boundary by clearing the low bits.
   function automatic logic [XLEN-1:0] word_align(input logic [XLEN-1:0] addr);
      return {addr[XLEN-1:2], 2'b00};
   endfunction

endpackage

// File: rtl/ifetch_unit_if.sv
// Bundle of the fetch unit's memory, execute-stage and decode-stage signals.
// master = the fetch unit, slave = the surrounding pipeline / memory.
interface ifetch_unit_if;
   import riscv_pkg::*;

   logic [XLEN-1:0] o_imem_addr;
   logic [XLEN-1:0] i_imem_data;
   logic            i_redirect_valid;
   logic [XLEN-1:0] i_redirect_pc;
   logic            i_halt;
   logic            o_inst_valid;
   logic [XLEN-1:0] o_inst;
   logic [XLEN-1:0] o_inst_pc;
   logic            i_inst_ready;
   logic            o_misalign;

   modport master (
      output o_imem_addr,
      input  i_imem_data,
      input  i_redirect_valid,
      input  i_redirect_pc,
      input  i_halt,
      output o_inst_valid,
      output o_inst,
      output o_inst_pc,
      input  i_inst_ready,
      output o_misalign
   );

   modport slave (
      input  o_imem_addr,
      output i_imem_data,
      output i_redirect_valid,
      output i_redirect_pc,
      output i_halt,
      input  o_inst_valid,
      input  o_inst,
      input  o_inst_pc,
      output i_inst_ready,
      input  o_misalign
   );

endinterface

// File: rtl/ifetch_buf.sv
// Small synchronous FIFO of fetched {pc, insn} entries. The head is exposed
// combinationally and reads as zero while empty. Push into a full buffer is
// accepted when a pop frees the head slot in the same cycle.
module ifetch_buf
   import riscv_pkg::*;
#(
   parameter  int DEPTH = 2,
   localparam int PTR_W = $clog2(DEPTH),
   localparam int CNT_W = PTR_W + 1
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             push,
   input  logic             pop,
   input  logic             flush,
   input  fetch_entry_t     push_entry,
   output logic [CNT_W-1:0] count,
   output fetch_entry_t     head
);

   fetch_entry_t     mem [DEPTH];
   logic [PTR_W-1:0] rd_ptr;
   logic [PTR_W-1:0] wr_ptr;
   logic             do_pop;
   logic             do_push;

   assign do_pop  = pop && (count != '0);
   assign do_push = push && ((count < CNT_W'(DEPTH)) || do_pop);

   // Pointer and occupancy bookkeeping; a flush empties the buffer outright.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rd_ptr <= '0;
         wr_ptr <= '0;
         count  <= '0;
      end else if (flush) begin
         rd_ptr <= '0;
         wr_ptr <= '0;
         count  <= '0;
      end else begin
         if (do_push) wr_ptr <= wr_ptr + PTR_W'(1);
         if (do_pop)  rd_ptr <= rd_ptr + PTR_W'(1);
         if (do_push && !do_pop)      count <= count + CNT_W'(1);
         else if (do_pop && !do_push) count <= count - CNT_W'(1);
      end
   end

   // Entry storage needs no reset: the head is masked whenever count is zero.
   always_ff @(posedge clk) begin
      if (do_push && !flush) mem[wr_ptr] <= push_entry;
   end

   // Present the oldest entry, or zeros when nothing is buffered.
   always_comb begin
      head = '0;
      if (count != '0) head = mem[rd_ptr];
   end

endmodule

// File: rtl/ifetch_unit.sv
// Instruction-fetch initiator. Drives the combinational imem with the fetch
// PC, buffers each returned word with its PC, and hands the oldest entry to
// decode over valid/ready. Redirects from execute flush and retarget fetch;
// halt stops fetching while the buffer keeps draining.
module ifetch_unit
   import riscv_pkg::*;
#(
   parameter logic [31:0] RESET_PC  = 32'h0000_0000,
   parameter int          BUF_DEPTH = 2
) (
   input logic          clk,
   input logic          rst_n,
   ifetch_unit_if.master bus
);

   localparam int CNT_W = $clog2(BUF_DEPTH) + 1;

   fetch_state_e     state;
   logic [XLEN-1:0]  fetch_pc;
   logic             misalign;
   logic [CNT_W-1:0] count;
   fetch_entry_t     head;
   fetch_entry_t     new_entry;
   logic             pop;
   logic             push;

   assign pop  = bus.o_inst_valid && bus.i_inst_ready;
   assign push = (state == S_RUN) && !bus.i_halt && !bus.i_redirect_valid &&
                 ((count < CNT_W'(BUF_DEPTH)) || pop);

   assign new_entry.pc   = fetch_pc;
   assign new_entry.insn = bus.i_imem_data;

   ifetch_buf #(
      .DEPTH (BUF_DEPTH)
   ) u_buf (
      .clk        (clk),
      .rst_n      (rst_n),
      .push       (push),
      .pop        (pop),
      .flush      (bus.i_redirect_valid),
      .push_entry (new_entry),
      .count      (count),
      .head       (head)
   );

   assign bus.o_imem_addr  = fetch_pc;
   assign bus.o_inst_valid = (count != '0);
   assign bus.o_inst       = head.insn;
   assign bus.o_inst_pc    = head.pc;
   assign bus.o_misalign   = misalign;

   // Fetch FSM, PC sequencing and misalign flag; redirect overrides everything.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state    <= S_BOOT;
         fetch_pc <= RESET_PC;
         misalign <= 1'b0;
      end else begin
         misalign <= bus.i_redirect_valid && (bus.i_redirect_pc[1:0] != 2'b00);
         if (bus.i_redirect_valid) begin
            fetch_pc <= word_align(bus.i_redirect_pc);
            state    <= S_RUN;
         end else begin
            if (push) fetch_pc <= fetch_pc + XLEN'(INSN_BYTES);
            case (state)
               S_BOOT:  state <= S_RUN;
               S_RUN:   if (bus.i_halt) state <= S_HALT;
               S_HALT:  state <= S_HALT;
               default: state <= S_BOOT;
            endcase
         end
      end
   end

endmodule

// File: tb/tb_ifetch_unit.sv
// Self-checking bench for ifetch_unit. The imem is modelled as word i at
// byte address 4*i holding i+0x100; each scenario queues the PCs decode
// should see and compares every accepted head against that queue.
module tb_ifetch_unit;
   import riscv_pkg::*;

   logic clk = 1'b0;
   logic rst_n = 1'b0;

   ifetch_unit_if bus ();

   int checks = 0;
   int failures = 0;
   logic [31:0] exp_q [$];
   logic [31:0] exp_pc;

   ifetch_unit #(
      .RESET_PC  (32'h0000_0000),
      .BUF_DEPTH (2)
   ) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   // Free-running clock, 10 time units per cycle.
   always #5 clk = ~clk;

   function automatic logic [31:0] imem_word(input logic [31:0] addr);
      return (addr >> 2) + 32'h100;
   endfunction

   assign bus.i_imem_data = imem_word(bus.o_imem_addr);

   // Global time limit so a stuck run still terminates with a report.
   initial begin
      #200000;
      $display("[TB] FAIL watchdog: got timeout, required completion");
      $fatal(1, "[TB] watchdog expired");
   end

   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      rst_n = 1'b0;
      bus.i_redirect_valid = 1'b0;
      bus.i_redirect_pc = '0;
      bus.i_halt = 1'b0;
      bus.i_inst_ready = 1'b0;
      exp_q.delete();
      @(posedge clk);
      #1;
      rst_n = 1'b1;
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      bus.i_redirect_valid = 1'b0;
      bus.i_redirect_pc = '0;
      bus.i_halt = 1'b0;
      bus.i_inst_ready = 1'b1;
      cyc();
      cyc();
      checks++; if (bus.o_inst_valid !== 1'b0) begin failures++; $display("[TB] FAIL reset_valid: got %b, required 0", bus.o_inst_valid); end
      checks++; if (bus.o_inst !== 32'h0) begin failures++; $display("[TB] FAIL reset_inst: got %h, required 0", bus.o_inst); end
      checks++; if (bus.o_inst_pc !== 32'h0) begin failures++; $display("[TB] FAIL reset_pc: got %h, required 0", bus.o_inst_pc); end
      checks++; if (bus.o_misalign !== 1'b0) begin failures++; $display("[TB] FAIL reset_misalign: got %b, required 0", bus.o_misalign); end
      checks++; if (bus.o_imem_addr !== 32'h0) begin failures++; $display("[TB] FAIL reset_addr: got %h, required 0", bus.o_imem_addr); end
   endtask

   task automatic test_stream();
      do_reset();
      bus.i_inst_ready = 1'b1;
      for (int i = 0; i < 5; i++) exp_q.push_back(32'(4 * i));
      cyc();
      checks++; if (bus.o_inst_valid !== 1'b0) begin failures++; $display("[TB] FAIL boot_idle: got valid=%b, required 0", bus.o_inst_valid); end
      for (int i = 0; i < 5; i++) begin
         cyc();
         checks++; if (bus.o_inst_valid !== 1'b1) begin failures++; $display("[TB] FAIL stream_gap: got valid=%b, required 1", bus.o_inst_valid); end
         if (bus.o_inst_valid && bus.i_inst_ready) begin
            checks++;
            if (exp_q.size() == 0) begin failures++; $display("[TB] FAIL stream_extra: got pc=%h, required none", bus.o_inst_pc); end
            else begin
               exp_pc = exp_q.pop_front();
               if (bus.o_inst_pc !== exp_pc || bus.o_inst !== imem_word(exp_pc)) begin failures++; $display("[TB] FAIL stream_data: got pc=%h inst=%h, required pc=%h inst=%h", bus.o_inst_pc, bus.o_inst, exp_pc, imem_word(exp_pc)); end
            end
         end
      end
      checks++; if (exp_q.size() != 0) begin failures++; $display("[TB] FAIL stream_missing: got %0d left, required 0", exp_q.size()); end
   endtask

   task automatic test_backpressure();
      do_reset();
      cyc();
      cyc();
      for (int i = 0; i < 5; i++) begin
         checks++; if (bus.o_inst_valid !== 1'b1 || bus.o_inst_pc !== 32'h0 || bus.o_inst !== 32'h100) begin failures++; $display("[TB] FAIL bp_hold: got valid=%b pc=%h inst=%h, required 1/0/100", bus.o_inst_valid, bus.o_inst_pc, bus.o_inst); end
         cyc();
      end
      checks++; if (bus.o_imem_addr !== 32'h8) begin failures++; $display("[TB] FAIL bp_addr: got %h, required 8", bus.o_imem_addr); end
      bus.i_inst_ready = 1'b1;
      for (int i = 0; i < 4; i++) exp_q.push_back(32'(4 * i));
      for (int i = 0; i < 4; i++) begin
         checks++; if (bus.o_inst_valid !== 1'b1) begin failures++; $display("[TB] FAIL bp_gap: got valid=%b, required 1", bus.o_inst_valid); end
         if (bus.o_inst_valid && bus.i_inst_ready) begin
            checks++;
            if (exp_q.size() == 0) begin failures++; $display("[TB] FAIL bp_extra: got pc=%h, required none", bus.o_inst_pc); end
            else begin
               exp_pc = exp_q.pop_front();
               if (bus.o_inst_pc !== exp_pc || bus.o_inst !== imem_word(exp_pc)) begin failures++; $display("[TB] FAIL bp_data: got pc=%h inst=%h, required pc=%h inst=%h", bus.o_inst_pc, bus.o_inst, exp_pc, imem_word(exp_pc)); end
            end
         end
         cyc();
      end
      checks++; if (exp_q.size() != 0) begin failures++; $display("[TB] FAIL bp_missing: got %0d left, required 0", exp_q.size()); end
   endtask

   task automatic test_redirect_full();
      do_reset();
      repeat (3) cyc();
      checks++; if (bus.o_imem_addr !== 32'h8) begin failures++; $display("[TB] FAIL rf_fill_addr: got %h, required 8", bus.o_imem_addr); end
      bus.i_redirect_valid = 1'b1;
      bus.i_redirect_pc = 32'h40;
      cyc();
      bus.i_redirect_valid = 1'b0;
      bus.i_inst_ready = 1'b1;
      checks++; if (bus.o_inst_valid !== 1'b0) begin failures++; $display("[TB] FAIL rf_flush: got valid=%b, required 0", bus.o_inst_valid); end
      checks++; if (bus.o_imem_addr !== 32'h40) begin failures++; $display("[TB] FAIL rf_addr: got %h, required 40", bus.o_imem_addr); end
      exp_q.push_back(32'h40); exp_q.push_back(32'h44); exp_q.push_back(32'h48);
      for (int i = 0; i < 3; i++) begin
         cyc();
         checks++; if (bus.o_inst_valid !== 1'b1) begin failures++; $display("[TB] FAIL rf_gap: got valid=%b, required 1", bus.o_inst_valid); end
         if (bus.o_inst_valid && bus.i_inst_ready) begin
            checks++;
            if (exp_q.size() == 0) begin failures++; $display("[TB] FAIL rf_extra: got pc=%h, required none", bus.o_inst_pc); end
            else begin
               exp_pc = exp_q.pop_front();
               if (bus.o_inst_pc !== exp_pc || bus.o_inst !== imem_word(exp_pc)) begin failures++; $display("[TB] FAIL rf_data: got pc=%h inst=%h, required pc=%h inst=%h", bus.o_inst_pc, bus.o_inst, exp_pc, imem_word(exp_pc)); end
            end
         end
      end
      checks++; if (exp_q.size() != 0) begin failures++; $display("[TB] FAIL rf_missing: got %0d left, required 0", exp_q.size()); end
   endtask

   task automatic test_misalign();
      bus.i_inst_ready = 1'b0;
      checks++; if (bus.o_misalign !== 1'b0) begin failures++; $display("[TB] FAIL ma_idle: got %b, required 0", bus.o_misalign); end
      bus.i_redirect_valid = 1'b1;
      bus.i_redirect_pc = 32'h42;
      cyc();
      bus.i_redirect_valid = 1'b0;
      bus.i_inst_ready = 1'b1;
      checks++; if (bus.o_misalign !== 1'b1) begin failures++; $display("[TB] FAIL ma_pulse: got %b, required 1", bus.o_misalign); end
      checks++; if (bus.o_inst_valid !== 1'b0) begin failures++; $display("[TB] FAIL ma_flush: got valid=%b, required 0", bus.o_inst_valid); end
      exp_q.push_back(32'h40); exp_q.push_back(32'h44);
      for (int i = 0; i < 2; i++) begin
         cyc();
         checks++; if (bus.o_misalign !== 1'b0) begin failures++; $display("[TB] FAIL ma_pulse_len: got %b, required 0", bus.o_misalign); end
         checks++; if (bus.o_inst_valid !== 1'b1) begin failures++; $display("[TB] FAIL ma_gap: got valid=%b, required 1", bus.o_inst_valid); end
         if (bus.o_inst_valid && bus.i_inst_ready) begin
            checks++;
            if (exp_q.size() == 0) begin failures++; $display("[TB] FAIL ma_extra: got pc=%h, required none", bus.o_inst_pc); end
            else begin
               exp_pc = exp_q.pop_front();
               if (bus.o_inst_pc !== exp_pc || bus.o_inst !== imem_word(exp_pc)) begin failures++; $display("[TB] FAIL ma_data: got pc=%h inst=%h, required pc=%h inst=%h", bus.o_inst_pc, bus.o_inst, exp_pc, imem_word(exp_pc)); end
            end
         end
      end
      checks++; if (exp_q.size() != 0) begin failures++; $display("[TB] FAIL ma_missing: got %0d left, required 0", exp_q.size()); end
   endtask

   task automatic test_halt();
      do_reset();
      repeat (3) cyc();
      bus.i_halt = 1'b1;
      cyc();
      bus.i_halt = 1'b0;
      bus.i_inst_ready = 1'b1;
      exp_q.push_back(32'h0); exp_q.push_back(32'h4);
      for (int i = 0; i < 4; i++) begin
         checks++; if (bus.o_imem_addr !== 32'h8) begin failures++; $display("[TB] FAIL halt_addr: got %h, required 8", bus.o_imem_addr); end
         if (bus.o_inst_valid && bus.i_inst_ready) begin
            checks++;
            if (exp_q.size() == 0) begin failures++; $display("[TB] FAIL halt_extra: got pc=%h, required none", bus.o_inst_pc); end
            else begin
               exp_pc = exp_q.pop_front();
               if (bus.o_inst_pc !== exp_pc || bus.o_inst !== imem_word(exp_pc)) begin failures++; $display("[TB] FAIL halt_data: got pc=%h inst=%h, required pc=%h inst=%h", bus.o_inst_pc, bus.o_inst, exp_pc, imem_word(exp_pc)); end
            end
         end
         cyc();
      end
      checks++; if (bus.o_inst_valid !== 1'b0) begin failures++; $display("[TB] FAIL halt_drained: got valid=%b, required 0", bus.o_inst_valid); end
      checks++; if (exp_q.size() != 0) begin failures++; $display("[TB] FAIL halt_missing: got %0d left, required 0", exp_q.size()); end

      bus.i_redirect_valid = 1'b1;
      bus.i_redirect_pc = 32'h80;
      cyc();
      bus.i_redirect_valid = 1'b0;
      checks++; if (bus.o_imem_addr !== 32'h80) begin failures++; $display("[TB] FAIL resume_addr: got %h, required 80", bus.o_imem_addr); end
      exp_q.push_back(32'h80); exp_q.push_back(32'h84);
      for (int i = 0; i < 2; i++) begin
         cyc();
         checks++; if (bus.o_inst_valid !== 1'b1) begin failures++; $display("[TB] FAIL resume_gap: got valid=%b, required 1", bus.o_inst_valid); end
         if (bus.o_inst_valid && bus.i_inst_ready) begin
            checks++;
            if (exp_q.size() == 0) begin failures++; $display("[TB] FAIL resume_extra: got pc=%h, required none", bus.o_inst_pc); end
            else begin
               exp_pc = exp_q.pop_front();
               if (bus.o_inst_pc !== exp_pc || bus.o_inst !== imem_word(exp_pc)) begin failures++; $display("[TB] FAIL resume_data: got pc=%h inst=%h, required pc=%h inst=%h", bus.o_inst_pc, bus.o_inst, exp_pc, imem_word(exp_pc)); end
            end
         end
      end
      checks++; if (exp_q.size() != 0) begin failures++; $display("[TB] FAIL resume_missing: got %0d left, required 0", exp_q.size()); end

      bus.i_inst_ready = 1'b0;
      bus.i_halt = 1'b1;
      bus.i_redirect_valid = 1'b1;
      bus.i_redirect_pc = 32'hC0;
      cyc();
      bus.i_halt = 1'b0;
      bus.i_redirect_valid = 1'b0;
      bus.i_inst_ready = 1'b1;
      checks++; if (bus.o_imem_addr !== 32'hC0) begin failures++; $display("[TB] FAIL hr_addr: got %h, required c0", bus.o_imem_addr); end
      exp_q.push_back(32'hC0); exp_q.push_back(32'hC4);
      for (int i = 0; i < 2; i++) begin
         cyc();
         checks++; if (bus.o_inst_valid !== 1'b1) begin failures++; $display("[TB] FAIL hr_gap: got valid=%b, required 1", bus.o_inst_valid); end
         if (bus.o_inst_valid && bus.i_inst_ready) begin
            checks++;
            if (exp_q.size() == 0) begin failures++; $display("[TB] FAIL hr_extra: got pc=%h, required none", bus.o_inst_pc); end
            else begin
               exp_pc = exp_q.pop_front();
               if (bus.o_inst_pc !== exp_pc || bus.o_inst !== imem_word(exp_pc)) begin failures++; $display("[TB] FAIL hr_data: got pc=%h inst=%h, required pc=%h inst=%h", bus.o_inst_pc, bus.o_inst, exp_pc, imem_word(exp_pc)); end
            end
         end
      end
      checks++; if (exp_q.size() != 0) begin failures++; $display("[TB] FAIL hr_missing: got %0d left, required 0", exp_q.size()); end
   endtask

   task automatic test_wrap_and_reset();
      bus.i_inst_ready = 1'b0;
      bus.i_redirect_valid = 1'b1;
      bus.i_redirect_pc = 32'hFFFF_FFFC;
      cyc();
      bus.i_redirect_valid = 1'b0;
      bus.i_inst_ready = 1'b1;
      exp_q.push_back(32'hFFFF_FFFC); exp_q.push_back(32'h0); exp_q.push_back(32'h4);
      for (int i = 0; i < 3; i++) begin
         cyc();
         checks++; if (bus.o_inst_valid !== 1'b1) begin failures++; $display("[TB] FAIL wrap_gap: got valid=%b, required 1", bus.o_inst_valid); end
         if (bus.o_inst_valid && bus.i_inst_ready) begin
            checks++;
            if (exp_q.size() == 0) begin failures++; $display("[TB] FAIL wrap_extra: got pc=%h, required none", bus.o_inst_pc); end
            else begin
               exp_pc = exp_q.pop_front();
               if (bus.o_inst_pc !== exp_pc || bus.o_inst !== imem_word(exp_pc)) begin failures++; $display("[TB] FAIL wrap_data: got pc=%h inst=%h, required pc=%h inst=%h", bus.o_inst_pc, bus.o_inst, exp_pc, imem_word(exp_pc)); end
            end
         end
      end
      checks++; if (exp_q.size() != 0) begin failures++; $display("[TB] FAIL wrap_missing: got %0d left, required 0", exp_q.size()); end

      bus.i_inst_ready = 1'b0;
      checks++; if (bus.o_inst_valid !== 1'b1) begin failures++; $display("[TB] FAIL pre_reset_valid: got %b, required 1", bus.o_inst_valid); end
      rst_n = 1'b0;
      #1;
      checks++; if (bus.o_inst_valid !== 1'b0) begin failures++; $display("[TB] FAIL async_valid: got %b, required 0", bus.o_inst_valid); end
      checks++; if (bus.o_inst_pc !== 32'h0 || bus.o_inst !== 32'h0) begin failures++; $display("[TB] FAIL async_head: got pc=%h inst=%h, required 0/0", bus.o_inst_pc, bus.o_inst); end
      checks++; if (bus.o_imem_addr !== 32'h0) begin failures++; $display("[TB] FAIL async_addr: got %h, required 0", bus.o_imem_addr); end
      exp_q.delete();
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      bus.i_inst_ready = 1'b1;
      exp_q.push_back(32'h0); exp_q.push_back(32'h4);
      cyc();
      checks++; if (bus.o_inst_valid !== 1'b0) begin failures++; $display("[TB] FAIL restart_boot: got valid=%b, required 0", bus.o_inst_valid); end
      for (int i = 0; i < 2; i++) begin
         cyc();
         checks++; if (bus.o_inst_valid !== 1'b1) begin failures++; $display("[TB] FAIL restart_gap: got valid=%b, required 1", bus.o_inst_valid); end
         if (bus.o_inst_valid && bus.i_inst_ready) begin
            checks++;
            if (exp_q.size() == 0) begin failures++; $display("[TB] FAIL restart_extra: got pc=%h, required none", bus.o_inst_pc); end
            else begin
               exp_pc = exp_q.pop_front();
               if (bus.o_inst_pc !== exp_pc || bus.o_inst !== imem_word(exp_pc)) begin failures++; $display("[TB] FAIL restart_data: got pc=%h inst=%h, required pc=%h inst=%h", bus.o_inst_pc, bus.o_inst, exp_pc, imem_word(exp_pc)); end
            end
         end
      end
      checks++; if (exp_q.size() != 0) begin failures++; $display("[TB] FAIL restart_missing: got %0d left, required 0", exp_q.size()); end
   endtask

   // Scenario sequence followed by the one-line summary.
   initial begin
      $display("[TB] ifetch_unit bench starting");
      test_reset();
      test_stream();
      test_backpressure();
      test_redirect_full();
      test_misalign();
      test_halt();
      test_wrap_and_reset();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
